// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: ALU op codes,
// FSM states and small op-decode helpers.
package ex_muldiv_pkg;

  localparam int MULDIV_OP_W = 3;

  typedef enum logic [MULDIV_OP_W-1:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // rs1 is treated as signed for these ops
  function automatic logic op_signed_a(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed_b(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// One UNROLL-wide iteration of shift-add multiply or restoring divide on a
// {hi, lo} accumulator; purely combinational.
module ex_muldiv_core #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic              is_div,
  input  logic [XLEN-1:0]   opnd,
  input  logic [2*XLEN-1:0] acc_in,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   part;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    hi   = acc_in[2*XLEN-1:XLEN];
    lo   = acc_in[XLEN-1:0];
    part = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        // hi = partial remainder, lo = dividend bits shifting out / quotient in
        part = {hi, lo[XLEN-1]};
        lo   = {lo[XLEN-2:0], 1'b0};
        if (part >= {1'b0, opnd}) begin
          part  = part - {1'b0, opnd};
          lo[0] = 1'b1;
        end
        hi = part[XLEN-1:0];
      end else begin
        // lo = multiplier shifting out, hi = running product high half
        part = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        lo   = {part[0], lo[XLEN-1:1]};
        hi   = part[XLEN:1];
      end
    end
    acc_out = {hi, lo};
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV-style MUL/DIV execution unit with stall/flush handshake.
// Define EX_MULDIV_FAST_MUL_EN for a single-stage array multiplier.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [MULDIV_OP_W-1:0] aluop_i,
  input  logic [XLEN-1:0]        reg1_i,
  input  logic [XLEN-1:0]        reg2_i,
  input  logic [4:0]             wd_i,
  input  logic                   flush_i,
  output logic                   stall_req_o,
  output logic                   done_o,
  output logic [4:0]             wd_o,
  output logic                   wreg_o,
  output logic [XLEN-1:0]        wdata_o
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state, state_n;
  logic [CW-1:0]     cnt;
  muldiv_op_e        op, op_in;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc, acc_step;
  logic [4:0]        wd_q;

  logic              accept, special, in_div, in_neg_a, in_neg_b;
  logic [XLEN-1:0]   mag_a, mag_b, spec_res, fix_res;
  logic [2*XLEN-1:0] prod_mag, prod;

  assign op_in  = muldiv_op_e'(aluop_i);
  assign accept = (state == S_IDLE) && start_i && !flush_i;
  assign in_div = op_is_div(op_in);

  ex_muldiv_core #(.XLEN(XLEN), .UNROLL(UNROLL)) u_core (
    .is_div  (op_is_div(op)),
    .opnd    (opnd),
    .acc_in  (acc),
    .acc_out (acc_step)
  );

  // Operand decode and the one-cycle special cases, straight from the inputs
  always_comb begin
    in_neg_a = op_signed_a(op_in) && reg1_i[XLEN-1];
    in_neg_b = op_signed_b(op_in) && reg2_i[XLEN-1];
    mag_a    = in_neg_a ? -reg1_i : reg1_i;
    mag_b    = in_neg_b ? -reg2_i : reg2_i;
    special  = 1'b0;
    spec_res = '0;
    if (in_div && reg2_i == '0) begin
      special  = 1'b1;
      spec_res = op_is_rem(op_in) ? reg1_i : '1;
    end else if (op_in inside {OP_DIV, OP_REM} && reg1_i == MIN_NEG && reg2_i == '1) begin
      special  = 1'b1;
      spec_res = op_is_rem(op_in) ? '0 : MIN_NEG;
    end else if (!in_div && (reg1_i == '0 || reg2_i == '0)) begin
      special  = 1'b1;
    end
  end

  // Sign correction and high/low select, used in FIX
  always_comb begin
`ifdef EX_MULDIV_FAST_MUL_EN
    prod_mag = {{XLEN{1'b0}}, opnd} * {{XLEN{1'b0}}, acc[XLEN-1:0]};
`else
    prod_mag = acc;
`endif
    prod    = (neg_a ^ neg_b) ? -prod_mag : prod_mag;
    fix_res = prod[XLEN-1:0];
    case (op)
      OP_MUL:                      fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      default:                     fix_res = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (special) state_n = S_DONE;
`ifdef EX_MULDIV_FAST_MUL_EN
          else if (!in_div) state_n = S_FIX;
`endif
          else state_n = S_CALC;
        end
      end
      S_CALC:  if (flush_i) state_n = S_IDLE; else if (cnt == CW'(1)) state_n = S_FIX;
      S_FIX:   state_n = flush_i ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  assign stall_req_o = accept || state == S_CALC || state == S_FIX;
  assign done_o      = (state == S_DONE);
  assign wreg_o      = done_o && (wd_o != 5'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; datapath registers are reset too so no X escapes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op      <= OP_MUL;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      wd_q    <= '0;
      wd_o    <= '0;
      wdata_o <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op    <= op_in;
        neg_a <= in_neg_a;
        neg_b <= in_neg_b;
        wd_q  <= wd_i;
        cnt   <= CW'(STEPS);
        opnd  <= in_div ? mag_b : mag_a;
        acc   <= {{XLEN{1'b0}}, in_div ? mag_a : mag_b};
      end else if (state == S_CALC) begin
        acc <= acc_step;
        cnt <= cnt - CW'(1);
      end
      if (state_n == S_DONE) begin
        wd_o <= (state == S_IDLE) ? wd_i : wd_q;
        if ((state == S_IDLE ? wd_i : wd_q) == 5'd0) wdata_o <= '0;
        else wdata_o <= (state == S_IDLE) ? spec_res : fix_res;
      end
    end
  end

endmodule
